mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (I$ / D$) line-memory arbiter with one transaction in flight,
// round-robin grant on ties and a bounded wait that reports a bus error on timeout.
module mem_arbiter #(
  parameter int ADDR_WIDTH     = 20,
  parameter int LINE_WIDTH     = 128,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ic_req_valid,
  input  logic [ADDR_WIDTH-1:0] ic_req_addr,
  output logic                  ic_rsp_valid,
  output logic [LINE_WIDTH-1:0] ic_rsp_data,
  output logic                  ic_rsp_bus_error,
  input  logic                  dc_req_valid,
  input  logic [ADDR_WIDTH-1:0] dc_req_addr,
  input  logic                  dc_req_is_store,
  input  logic [LINE_WIDTH-1:0] dc_req_data,
  output logic                  dc_rsp_valid,
  output logic [LINE_WIDTH-1:0] dc_rsp_data,
  output logic                  dc_rsp_bus_error,
  output logic                  mem_req_valid,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic                  mem_req_is_store,
  output logic [LINE_WIDTH-1:0] mem_req_data,
  input  logic                  mem_rsp_valid,
  input  logic [LINE_WIDTH-1:0] mem_rsp_data,
  input  logic                  mem_rsp_bus_error,
  output logic                  busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t                state_q;
  logic                  owner_dc_q;
  logic                  last_grant_dc_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  store_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic [LINE_WIDTH-1:0] rdata_q;
  logic                  rerr_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  mem_req_valid_q;
  logic                  ic_rsp_valid_q;
  logic                  dc_rsp_valid_q;
  logic                  busy_q;

  logic grant_dc_d;
  logic any_req_d;
  logic rsp_take_d;
  logic timeout_d;

  always_comb begin
    // On a tie the D$ wins unless it was the previous winner.
    grant_dc_d = dc_req_valid && (!ic_req_valid || !last_grant_dc_q);
    any_req_d  = ic_req_valid || dc_req_valid;
    rsp_take_d = mem_rsp_valid && (state_q == REQ || state_q == WAIT);
    timeout_d  = !mem_rsp_valid && (state_q == WAIT) && (cnt_q == CNT_LAST);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      owner_dc_q      <= 1'b0;
      last_grant_dc_q <= 1'b0;
      addr_q          <= '0;
      store_q         <= 1'b0;
      wdata_q         <= '0;
      rdata_q         <= '0;
      rerr_q          <= 1'b0;
      cnt_q           <= '0;
      mem_req_valid_q <= 1'b0;
      ic_rsp_valid_q  <= 1'b0;
      dc_rsp_valid_q  <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      mem_req_valid_q <= 1'b0;
      ic_rsp_valid_q  <= 1'b0;
      dc_rsp_valid_q  <= 1'b0;

      if (rsp_take_d || timeout_d) begin
        // A real response in the final wait cycle takes precedence over the timeout.
        rdata_q        <= rsp_take_d ? mem_rsp_data : '0;
        rerr_q         <= rsp_take_d ? mem_rsp_bus_error : 1'b1;
        ic_rsp_valid_q <= !owner_dc_q;
        dc_rsp_valid_q <= owner_dc_q;
        state_q        <= RESP;
      end else begin
        case (state_q)
          IDLE: begin
            if (any_req_d) begin
              owner_dc_q      <= grant_dc_d;
              last_grant_dc_q <= grant_dc_d;
              addr_q          <= grant_dc_d ? dc_req_addr : ic_req_addr;
              store_q         <= grant_dc_d && dc_req_is_store;
              wdata_q         <= grant_dc_d ? dc_req_data : '0;
              mem_req_valid_q <= 1'b1;
              busy_q          <= 1'b1;
              state_q         <= REQ;
            end
          end
          REQ: begin
            cnt_q   <= '0;
            state_q <= WAIT;
          end
          WAIT: begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
          RESP: begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign mem_req_valid    = mem_req_valid_q;
  assign mem_req_addr     = addr_q;
  assign mem_req_is_store = store_q;
  assign mem_req_data     = wdata_q;
  assign busy             = busy_q;

  // Response payload is only ever visible on the owner's port during its valid cycle.
  assign ic_rsp_valid     = ic_rsp_valid_q;
  assign ic_rsp_data      = ic_rsp_valid_q ? rdata_q : '0;
  assign ic_rsp_bus_error = ic_rsp_valid_q & rerr_q;
  assign dc_rsp_valid     = dc_rsp_valid_q;
  assign dc_rsp_data      = dc_rsp_valid_q ? rdata_q : '0;
  assign dc_rsp_bus_error = dc_rsp_valid_q & rerr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario bench for mem_arbiter: a delay-programmable memory model answers requests and
// expected responses are queued when requests are driven, then popped as responses appear.
module tb_mem_arbiter;
  localparam int AW = 20;
  localparam int LW = 128;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          ic_req_valid = 1'b0;
  logic [AW-1:0] ic_req_addr = '0;
  logic          ic_rsp_valid;
  logic [LW-1:0] ic_rsp_data;
  logic          ic_rsp_bus_error;
  logic          dc_req_valid = 1'b0;
  logic [AW-1:0] dc_req_addr = '0;
  logic          dc_req_is_store = 1'b0;
  logic [LW-1:0] dc_req_data = '0;
  logic          dc_rsp_valid;
  logic [LW-1:0] dc_rsp_data;
  logic          dc_rsp_bus_error;
  logic          mem_req_valid;
  logic [AW-1:0] mem_req_addr;
  logic          mem_req_is_store;
  logic [LW-1:0] mem_req_data;
  logic          mem_rsp_valid = 1'b0;
  logic [LW-1:0] mem_rsp_data = '0;
  logic          mem_rsp_bus_error = 1'b0;
  logic          busy;

  always #5 clock = ~clock;

  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr),
    .ic_rsp_valid(ic_rsp_valid), .ic_rsp_data(ic_rsp_data), .ic_rsp_bus_error(ic_rsp_bus_error),
    .dc_req_valid(dc_req_valid), .dc_req_addr(dc_req_addr), .dc_req_is_store(dc_req_is_store),
    .dc_req_data(dc_req_data),
    .dc_rsp_valid(dc_rsp_valid), .dc_rsp_data(dc_rsp_data), .dc_rsp_bus_error(dc_rsp_bus_error),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_is_store(mem_req_is_store),
    .mem_req_data(mem_req_data),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_bus_error(mem_rsp_bus_error),
    .busy(busy)
  );

  typedef struct {
    bit            is_dc;
    logic [LW-1:0] data;
    bit            err;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   compared = 0;
  int   mismatched = 0;

  // Memory model: mem_delay = cycles from request cycle to response cycle, -1 = never answer.
  int            mem_delay = 1;
  bit            mem_err = 1'b0;
  bit            mem_pending = 1'b0;
  int            mem_cnt = 0;
  logic [AW-1:0] mem_addr = '0;

  function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
    return {32'hFEED0000 ^ {12'd0, a}, 32'h12345678, ~{12'd0, a}, {12'd0, a}};
  endfunction

  always @(posedge clock) begin
    #2;
    mem_rsp_valid = 1'b0;
    mem_rsp_data = '0;
    mem_rsp_bus_error = 1'b0;
    if (mem_pending) begin
      if (mem_cnt == 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data = line_of(mem_addr);
        mem_rsp_bus_error = mem_err;
        mem_pending = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
    if (mem_req_valid) begin
      mem_addr = mem_req_addr;
      if (mem_delay == 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data = line_of(mem_addr);
        mem_rsp_bus_error = mem_err;
        mem_pending = 1'b0;
      end else if (mem_delay > 0) begin
        mem_pending = 1'b1;
        mem_cnt = mem_delay - 1;
      end else begin
        mem_pending = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_rsp(input int bound, output int cyc, output bit ok);
    ok = 1'b0;
    cyc = 0;
    while (cyc < bound && !ok) begin
      tick();
      cyc++;
      if (ic_rsp_valid || dc_rsp_valid) ok = 1'b1;
    end
  endtask

  task automatic wait_mem_req(input int bound, output bit ok);
    int cyc;
    ok = 1'b0;
    cyc = 0;
    while (cyc < bound && !ok) begin
      tick();
      cyc++;
      if (mem_req_valid) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    compared++; if (busy !== 1'b0 || mem_req_valid !== 1'b0) begin mismatched++;
      $display("FAIL reset_async: busy=%b mem_req_valid=%b, want 0/0", busy, mem_req_valid); end
    compared++; if (ic_rsp_valid !== 1'b0 || dc_rsp_valid !== 1'b0 || mem_req_addr !== '0 || mem_req_data !== '0) begin mismatched++;
      $display("FAIL reset_outputs: ic_v=%b dc_v=%b addr=%h, want all 0", ic_rsp_valid, dc_rsp_valid, mem_req_addr); end
    tick(); tick();
    reset = 1'b0;
    tick();
    compared++; if (busy !== 1'b0 || mem_req_valid !== 1'b0 || mem_req_is_store !== 1'b0) begin mismatched++;
      $display("FAIL reset_after: busy=%b mem_req_valid=%b, want 0/0", busy, mem_req_valid); end
    $display("reset: done");
  endtask

  task automatic test_tie_first_grant();
    bit ok; int cyc;
    mem_delay = 2; mem_err = 1'b0;
    dc_req_addr = 20'h0D0D0; dc_req_is_store = 1'b0; dc_req_data = '0;
    ic_req_addr = 20'h01C1C;
    dc_req_valid = 1'b1; ic_req_valid = 1'b1;
    exp_q.push_back('{is_dc: 1'b1, data: line_of(20'h0D0D0), err: 1'b0});
    exp_q.push_back('{is_dc: 1'b0, data: line_of(20'h01C1C), err: 1'b0});
    tick();
    compared++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 20'h0D0D0) begin mismatched++;
      $display("FAIL tie_mem_req: valid=%b addr=%h, want 1/0d0d0", mem_req_valid, mem_req_addr); end
    tick();
    compared++; if (mem_req_valid !== 1'b0 || busy !== 1'b1) begin mismatched++;
      $display("FAIL tie_req_pulse: valid=%b busy=%b, want 0/1", mem_req_valid, busy); end
    wait_rsp(100, cyc, ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL tie_rsp1: no response in 100 cycles"); end
    e = exp_q.pop_front();
    compared++; if (dc_rsp_valid !== e.is_dc || ic_rsp_valid !== !e.is_dc) begin mismatched++;
      $display("FAIL tie_owner1: ic=%b dc=%b, want dc=%b", ic_rsp_valid, dc_rsp_valid, e.is_dc); end
    compared++; if (dc_rsp_data !== e.data || dc_rsp_bus_error !== e.err || ic_rsp_data !== '0) begin mismatched++;
      $display("FAIL tie_data1: data=%h err=%b, want %h/%b", dc_rsp_data, dc_rsp_bus_error, e.data, e.err); end
    $display("tie: D$ response addr=%h data=%h", dc_req_addr, dc_rsp_data);
    dc_req_valid = 1'b0;
    dc_req_is_store = 1'b1; dc_req_data = {LW{1'b1}};
    wait_mem_req(20, ok);
    compared++; if (!ok || mem_req_addr !== 20'h01C1C || mem_req_is_store !== 1'b0 || mem_req_data !== '0) begin mismatched++;
      $display("FAIL tie_ic_req: ok=%b addr=%h st=%b data=%h, want 1/01c1c/0/0", ok, mem_req_addr, mem_req_is_store, mem_req_data); end
    wait_rsp(100, cyc, ok);
    e = exp_q.pop_front();
    compared++; if (!ok || ic_rsp_valid !== 1'b1 || dc_rsp_valid !== 1'b0 || ic_rsp_data !== e.data || ic_rsp_bus_error !== e.err) begin mismatched++;
      $display("FAIL tie_rsp2: ok=%b ic=%b dc=%b data=%h, want ic data %h", ok, ic_rsp_valid, dc_rsp_valid, ic_rsp_data, e.data); end
    $display("tie: I$ response addr=%h data=%h", ic_req_addr, ic_rsp_data);
    ic_req_valid = 1'b0; dc_req_is_store = 1'b0; dc_req_data = '0;
    tick();
  endtask

  task automatic test_dc_store();
    bit ok; int cyc;
    mem_delay = 3; mem_err = 1'b0;
    dc_req_addr = 20'h00040; dc_req_is_store = 1'b1; dc_req_data = {16{8'hA5}};
    dc_req_valid = 1'b1;
    exp_q.push_back('{is_dc: 1'b1, data: line_of(20'h00040), err: 1'b0});
    wait_mem_req(20, ok);
    compared++; if (!ok || mem_req_addr !== 20'h00040 || mem_req_is_store !== 1'b1 || mem_req_data !== {16{8'hA5}}) begin mismatched++;
      $display("FAIL store_req: ok=%b addr=%h st=%b data=%h", ok, mem_req_addr, mem_req_is_store, mem_req_data); end
    wait_rsp(100, cyc, ok);
    compared++; if (!ok || cyc != 4) begin mismatched++;
      $display("FAIL store_latency: ok=%b cycles=%0d, want 4", ok, cyc); end
    e = exp_q.pop_front();
    compared++; if (dc_rsp_valid !== 1'b1 || ic_rsp_valid !== 1'b0 || dc_rsp_data !== e.data || dc_rsp_bus_error !== e.err) begin mismatched++;
      $display("FAIL store_rsp: ic=%b dc=%b data=%h err=%b, want dc data %h err 0", ic_rsp_valid, dc_rsp_valid, dc_rsp_data, dc_rsp_bus_error, e.data); end
    compared++; if (mem_req_addr !== 20'h00040 || mem_req_data !== {16{8'hA5}} || mem_req_is_store !== 1'b1) begin mismatched++;
      $display("FAIL store_hold: addr=%h st=%b in RESP, want 00040/1", mem_req_addr, mem_req_is_store); end
    $display("store: addr=%h rsp after %0d cycles err=%b", dc_req_addr, cyc, dc_rsp_bus_error);
    dc_req_valid = 1'b0; dc_req_is_store = 1'b0; dc_req_data = '0;
    tick();
  endtask

  task automatic test_zero_latency();
    bit ok; int cyc;
    mem_delay = 0; mem_err = 1'b0;
    dc_req_addr = 20'h00123; dc_req_valid = 1'b1;
    exp_q.push_back('{is_dc: 1'b1, data: line_of(20'h00123), err: 1'b0});
    wait_mem_req(20, ok);
    wait_rsp(100, cyc, ok);
    e = exp_q.pop_front();
    compared++; if (!ok || cyc != 1 || dc_rsp_valid !== 1'b1 || dc_rsp_data !== e.data) begin mismatched++;
      $display("FAIL zero_lat: ok=%b cycles=%0d data=%h, want 1 cycle data %h", ok, cyc, dc_rsp_data, e.data); end
    $display("zero_latency: rsp after %0d cycles", cyc);
    dc_req_valid = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    bit ok; int cyc;
    mem_delay = -1; mem_err = 1'b0;
    ic_req_addr = 20'hABCDE; ic_req_valid = 1'b1;
    exp_q.push_back('{is_dc: 1'b0, data: '0, err: 1'b1});
    wait_mem_req(20, ok);
    wait_rsp(200, cyc, ok);
    e = exp_q.pop_front();
    // WAIT is entered one cycle after the request cycle, so 64 + 1.
    compared++; if (!ok || cyc != 65) begin mismatched++;
      $display("FAIL timeout_latency: ok=%b cycles=%0d, want 65", ok, cyc); end
    compared++; if (ic_rsp_valid !== 1'b1 || ic_rsp_bus_error !== e.err || ic_rsp_data !== e.data || dc_rsp_valid !== 1'b0) begin mismatched++;
      $display("FAIL timeout_rsp: ic=%b err=%b data=%h dc=%b, want 1/1/0/0", ic_rsp_valid, ic_rsp_bus_error, ic_rsp_data, dc_rsp_valid); end
    $display("timeout: rsp after %0d cycles err=%b", cyc, ic_rsp_bus_error);
    ic_req_valid = 1'b0;
    tick();
  endtask

  task automatic test_timeout_race();
    bit ok; int cyc;
    mem_delay = 64; mem_err = 1'b0;
    ic_req_addr = 20'h0BEEF; ic_req_valid = 1'b1;
    exp_q.push_back('{is_dc: 1'b0, data: line_of(20'h0BEEF), err: 1'b0});
    wait_mem_req(20, ok);
    wait_rsp(200, cyc, ok);
    e = exp_q.pop_front();
    compared++; if (!ok || cyc != 65 || ic_rsp_valid !== 1'b1 || ic_rsp_bus_error !== e.err || ic_rsp_data !== e.data) begin mismatched++;
      $display("FAIL race_rsp: cycles=%0d err=%b data=%h, want 65/0/%h", cyc, ic_rsp_bus_error, ic_rsp_data, e.data); end
    $display("timeout_race: rsp after %0d cycles err=%b", cyc, ic_rsp_bus_error);
    ic_req_valid = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    bit ok; int cyc;
    mem_delay = 1; mem_err = 1'b0;
    ic_req_addr = 20'h11111; dc_req_addr = 20'h22222; dc_req_is_store = 1'b0;
    for (int i = 0; i < 6; i++)
      exp_q.push_back('{is_dc: (i % 2 == 0), data: (i % 2 == 0) ? line_of(20'h22222) : line_of(20'h11111), err: 1'b0});
    ic_req_valid = 1'b1; dc_req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_rsp(100, cyc, ok);
      e = exp_q.pop_front();
      compared++; if (!ok || dc_rsp_valid !== e.is_dc || ic_rsp_valid !== !e.is_dc) begin mismatched++;
        $display("FAIL rr_owner[%0d]: ic=%b dc=%b, want dc=%b", i, ic_rsp_valid, dc_rsp_valid, e.is_dc); end
      compared++; if ((e.is_dc ? dc_rsp_data : ic_rsp_data) !== e.data) begin mismatched++;
        $display("FAIL rr_data[%0d]: ic=%h dc=%h, want %h", i, ic_rsp_data, dc_rsp_data, e.data); end
      $display("round_robin[%0d]: granted %s", i, dc_rsp_valid ? "D$" : "I$");
    end
    ic_req_valid = 1'b0; dc_req_valid = 1'b0;
    tick();
  endtask

  task automatic test_bus_error();
    bit ok; int cyc;
    mem_delay = 2; mem_err = 1'b1;
    dc_req_addr = 20'h00F00; dc_req_is_store = 1'b0; dc_req_valid = 1'b1;
    exp_q.push_back('{is_dc: 1'b1, data: line_of(20'h00F00), err: 1'b1});
    wait_mem_req(20, ok);
    wait_rsp(100, cyc, ok);
    e = exp_q.pop_front();
    compared++; if (!ok || dc_rsp_valid !== 1'b1 || dc_rsp_bus_error !== e.err || dc_rsp_data !== e.data || ic_rsp_bus_error !== 1'b0) begin mismatched++;
      $display("FAIL buserr_rsp: dc=%b err=%b data=%h, want 1/1/%h", dc_rsp_valid, dc_rsp_bus_error, dc_rsp_data, e.data); end
    dc_req_valid = 1'b0;
    tick();
    compared++; if (dc_rsp_valid !== 1'b0 || dc_rsp_bus_error !== 1'b0 || busy !== 1'b0) begin mismatched++;
      $display("FAIL buserr_idle: dc=%b err=%b busy=%b, want 0/0/0", dc_rsp_valid, dc_rsp_bus_error, busy); end
    $display("bus_error: err=%b then idle", e.err);
    mem_err = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok; int cyc; int bad;
    mem_delay = 8; mem_err = 1'b0;
    ic_req_addr = 20'h00777; ic_req_valid = 1'b1;
    wait_mem_req(20, ok);
    tick(); tick();
    reset = 1'b1;
    #1;
    compared++; if (busy !== 1'b0 || mem_req_addr !== '0 || ic_rsp_valid !== 1'b0) begin mismatched++;
      $display("FAIL midreset_async: busy=%b addr=%h, want 0/0", busy, mem_req_addr); end
    ic_req_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ic_rsp_valid || dc_rsp_valid || busy) bad++;
    end
    compared++; if (bad != 0) begin mismatched++;
      $display("FAIL midreset_quiet: %0d cycles with rsp_valid/busy, want 0", bad); end
    mem_delay = 1;
    dc_req_addr = 20'h00ABC; dc_req_is_store = 1'b0; dc_req_valid = 1'b1;
    exp_q.push_back('{is_dc: 1'b1, data: line_of(20'h00ABC), err: 1'b0});
    wait_mem_req(20, ok);
    compared++; if (!ok || mem_req_addr !== 20'h00ABC) begin mismatched++;
      $display("FAIL midreset_req: ok=%b addr=%h, want 1/00abc", ok, mem_req_addr); end
    wait_rsp(100, cyc, ok);
    e = exp_q.pop_front();
    compared++; if (!ok || dc_rsp_valid !== 1'b1 || dc_rsp_data !== e.data || dc_rsp_bus_error !== e.err) begin mismatched++;
      $display("FAIL midreset_rsp: dc=%b data=%h, want 1/%h", dc_rsp_valid, dc_rsp_data, e.data); end
    $display("reset_mid: aborted txn silent, next served data=%h", dc_rsp_data);
    dc_req_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_tie_first_grant();
    test_dc_store();
    test_zero_latency();
    test_timeout();
    test_timeout_race();
    test_round_robin();
    test_bus_error();
    test_reset_mid();
    compared++; if (exp_q.size() != 0) begin mismatched++;
      $display("FAIL scoreboard_drain: %0d expected responses left, want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
